// File: rtl/normshift_sched.sv
// normshift_sched: shares the normalization shifter between the FMA/convert pipeline and divsqrt.
// Optional NORMSHIFT_PERF_EN adds StallCntM / DivWaitCntM performance counters.
module normshift_sched #(
   parameter int LOGNORMSHIFTSZ = 8,
   parameter int HOLD_MAX       = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      PipeReqValid,
   input  logic [LOGNORMSHIFTSZ-1:0] PipeShiftAmt,
   input  logic                      DivDone,
   input  logic [LOGNORMSHIFTSZ-1:0] DivShiftAmt,
   input  logic                      DivResSubnorm,
   input  logic                      DivFlush,
   output logic                      PipeStall,
   output logic                      DivBusy,
   output logic                      ShiftValidM,
   output logic                      ShiftSelDivM,
   output logic [LOGNORMSHIFTSZ-1:0] ShiftAmtM,
   output logic                      ShiftSubnormM
`ifdef NORMSHIFT_PERF_EN
   ,
   output logic [31:0]               StallCntM,
   output logic [31:0]               DivWaitCntM
`endif
);

   typedef enum logic {IDLE, PEND} state_t;

   localparam logic [3:0] HOLD_MAX_C = 4'(HOLD_MAX);

   state_t                    state;
   logic [3:0]                Cnt;
   logic [LOGNORMSHIFTSZ-1:0] HAmt;
   logic                      HSub;

   // Forced grant: the held divsqrt result has lost HOLD_MAX times, so the pipeline yields.
   assign PipeStall = (state == PEND) && !DivFlush && PipeReqValid && (Cnt >= HOLD_MAX_C);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         Cnt           <= 4'd0;
         HAmt          <= '0;
         HSub          <= 1'b0;
         DivBusy       <= 1'b0;
         ShiftValidM   <= 1'b0;
         ShiftSelDivM  <= 1'b0;
         ShiftAmtM     <= '0;
         ShiftSubnormM <= 1'b0;
      end else begin
         ShiftValidM <= 1'b0;
         case (state)
            IDLE: begin
               if (DivDone && !DivFlush && !PipeReqValid) begin
                  ShiftValidM   <= 1'b1;
                  ShiftSelDivM  <= 1'b1;
                  ShiftAmtM     <= DivShiftAmt;
                  ShiftSubnormM <= DivResSubnorm;
               end else begin
                  if (PipeReqValid) begin
                     ShiftValidM   <= 1'b1;
                     ShiftSelDivM  <= 1'b0;
                     ShiftAmtM     <= PipeShiftAmt;
                     ShiftSubnormM <= 1'b0;
                  end
                  if (DivDone && !DivFlush) begin
                     HAmt    <= DivShiftAmt;
                     HSub    <= DivResSubnorm;
                     Cnt     <= 4'd1;
                     state   <= PEND;
                     DivBusy <= 1'b1;
                  end
               end
            end
            PEND: begin
               // A DivDone arriving here is ignored; the held entry wins.
               if (DivFlush) begin
                  if (PipeReqValid) begin
                     ShiftValidM   <= 1'b1;
                     ShiftSelDivM  <= 1'b0;
                     ShiftAmtM     <= PipeShiftAmt;
                     ShiftSubnormM <= 1'b0;
                  end
                  state   <= IDLE;
                  Cnt     <= 4'd0;
                  DivBusy <= 1'b0;
               end else if (!PipeReqValid || (Cnt >= HOLD_MAX_C)) begin
                  ShiftValidM   <= 1'b1;
                  ShiftSelDivM  <= 1'b1;
                  ShiftAmtM     <= HAmt;
                  ShiftSubnormM <= HSub;
                  state         <= IDLE;
                  Cnt           <= 4'd0;
                  DivBusy       <= 1'b0;
               end else begin
                  ShiftValidM   <= 1'b1;
                  ShiftSelDivM  <= 1'b0;
                  ShiftAmtM     <= PipeShiftAmt;
                  ShiftSubnormM <= 1'b0;
                  Cnt           <= Cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef NORMSHIFT_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         StallCntM   <= 32'd0;
         DivWaitCntM <= 32'd0;
      end else begin
         if (PipeStall)
            StallCntM <= StallCntM + 32'd1;
         if (state == PEND)
            DivWaitCntM <= DivWaitCntM + 32'd1;
      end
   end
`endif

endmodule

// File: doc/normshift_sched.md
Name: normshift_sched

Overview:
- Arbitrates the shared post-processing normalization shifter between two requesters: the FMA/convert pipeline and the divsqrt unit.
- The divsqrt unit finishes on a cycle independent of the pipeline, so its shift amount (from divshiftcalc) is captured into a one-entry hold buffer.
- The pipeline has priority, with a bounded wait for divsqrt: after HOLD_MAX lost cycles the pipeline is stalled and divsqrt is granted.
- Output is a registered shift command for the normalization shifter.

Parameters:
- LOGNORMSHIFTSZ, 8, width of shift amounts.
- HOLD_MAX, 2, maximum consecutive cycles a pending divsqrt result loses to the pipeline. Legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- PipeReqValid  in  1  pipeline needs the shifter this cycle
- PipeShiftAmt  in  LOGNORMSHIFTSZ  pipeline shift amount
- DivDone  in  1  divsqrt result ready; single-cycle pulse
- DivShiftAmt  in  LOGNORMSHIFTSZ  divsqrt shift amount, valid with DivDone
- DivResSubnorm  in  1  divsqrt result subnormal, valid with DivDone
- DivFlush  in  1  kill any pending or arriving divsqrt result
- PipeStall  out  1  combinational; stall the pipeline this cycle
- DivBusy  out  1  registered; hold buffer occupied, divsqrt must not pulse DivDone
- ShiftValidM  out  1  registered; a shift command was issued
- ShiftSelDivM  out  1  registered; 1 = command belongs to divsqrt
- ShiftAmtM  out  LOGNORMSHIFTSZ  registered granted shift amount
- ShiftSubnormM  out  1  registered; DivResSubnorm for divsqrt grants, 0 for pipeline grants

Behaviour:
- State machine has two states, IDLE and PEND.
- Internal wait counter Cnt is 4 bits.
- Hold registers: HAmt, HSub.
- Reset (asynchronous, any time including mid-PEND):
  - state=IDLE, Cnt=0, hold registers cleared.
  - All registered outputs = 0.
  - The pending result is discarded.
- Grant rule: every cycle issues at most one grant. A grant registers ShiftValidM=1 plus the Sel/Amt/Subnorm values on the next clock edge (latency 1).
- No grant: ShiftValidM=0 next cycle; ShiftSelDivM, ShiftAmtM and ShiftSubnormM hold their previous values.
- IDLE:
  - DivFlush=1: any DivDone is ignored. A pipeline request is still granted if present. Stay IDLE.
  - DivDone=1 and PipeReqValid=0: bypass-grant divsqrt (Amt=DivShiftAmt, Sub=DivResSubnorm). Stay IDLE.
  - DivDone=1 and PipeReqValid=1: grant pipeline, capture HAmt/HSub, Cnt<=1, go to PEND.
  - Otherwise: grant pipeline if PipeReqValid=1. Stay IDLE.
- PEND (DivBusy=1):
  - DivFlush=1: grant pipeline if requested, go to IDLE, Cnt<=0. Flush has priority over force.
  - PipeReqValid=0: grant divsqrt from the hold registers, go to IDLE.
  - PipeReqValid=1 and Cnt<HOLD_MAX: grant pipeline, Cnt<=Cnt+1.
  - PipeReqValid=1 and Cnt==HOLD_MAX: PipeStall=1 (combinational, same cycle), grant divsqrt, go to IDLE. The pipeline request is not granted and must be re-presented.
  - DivDone in PEND is a protocol violation: the new result is dropped and the held entry is retained.
- PipeStall is 0 in every case except the force case.
- DivBusy is registered: 1 exactly while state=PEND.
- Throughput: a divsqrt result waits at most HOLD_MAX+1 cycles from DivDone to grant.

Optional Feature:
- Macro NORMSHIFT_PERF_EN.
- When defined, adds two output ports:
  - StallCntM [31:0]: increments each cycle PipeStall=1.
  - DivWaitCntM [31:0]: increments each cycle state=PEND.
  - Both reset to 0 and wrap from 2^32-1 to 0.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset asserted mid-PEND with HAmt=0x2A → all outputs 0 immediately, DivBusy=0. After release, PipeReqValid=0 for one cycle → ShiftValidM=0, nothing is granted.
- DivDone=1 with DivShiftAmt=0x34, DivResSubnorm=1, PipeReqValid=0 → next cycle ShiftValidM=1, ShiftSelDivM=1, ShiftAmtM=0x34, ShiftSubnormM=1. DivBusy stays 0.
- DivDone with Amt=0x10 while PipeReqValid=1 (PipeShiftAmt=0x05) continuously, HOLD_MAX=2 → two pipeline grants (Amt 0x05), then PipeStall=1 for one cycle. Next cycle ShiftSelDivM=1, ShiftAmtM=0x10; DivBusy falls.
- PEND with PipeReqValid dropping after one pipeline grant → divsqrt granted the next cycle with the held amount. PipeStall never asserted.
- DivFlush=1 while PEND and PipeReqValid=1 → pipeline granted, state IDLE, no divsqrt grant ever issued. DivDone+DivFlush in IDLE → no divsqrt grant.
- With NORMSHIFT_PERF_EN defined, run the forced-stall scenario three times → StallCntM=3, DivWaitCntM=6.
